// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with bounded burst lock for the single-port image memory.
// Optional grant/wait statistics counters are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int AW        = 16,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_en,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_dataW,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   input  logic          m1_en,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_dataW,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m_dataR,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] dataW,
   output logic          en,
   output logic          we,
   input  logic [DW-1:0] dataR
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]   stat_gnt0,
   output logic [31:0]   stat_gnt1,
   output logic [31:0]   stat_wait
`endif
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t     state, state_nxt;
   logic [3:0] burst_cnt, burst_cnt_nxt;
   logic       rr_last, rr_last_nxt;
   logic [1:0] rd_pend;
   logic       gnt0_c, gnt1_c;

   function automatic logic [3:0] sat_inc(input logic [3:0] c);
      return (c < MAX_B) ? c + 4'd1 : MAX_B;
   endfunction

   always_comb begin
      gnt0_c        = 1'b0;
      gnt1_c        = 1'b0;
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      rr_last_nxt   = rr_last;
      case (state)
         IDLE: begin
            // On a tie the requester that did not own the port last wins
            if (m0_en && (!m1_en || rr_last)) begin
               gnt0_c        = 1'b1;
               state_nxt     = OWN0;
               burst_cnt_nxt = 4'd1;
            end else if (m1_en) begin
               gnt1_c        = 1'b1;
               state_nxt     = OWN1;
               burst_cnt_nxt = 4'd1;
            end
         end
         OWN0: begin
            if (m0_en && (!m1_en || burst_cnt < MAX_B)) begin
               gnt0_c        = 1'b1;
               burst_cnt_nxt = sat_inc(burst_cnt);
            end else if (m1_en) begin
               gnt1_c        = 1'b1;
               state_nxt     = OWN1;
               burst_cnt_nxt = 4'd1;
               rr_last_nxt   = 1'b0;
            end else begin
               state_nxt   = IDLE;
               rr_last_nxt = 1'b0;
            end
         end
         OWN1: begin
            if (m1_en && (!m0_en || burst_cnt < MAX_B)) begin
               gnt1_c        = 1'b1;
               burst_cnt_nxt = sat_inc(burst_cnt);
            end else if (m0_en) begin
               gnt0_c        = 1'b1;
               state_nxt     = OWN0;
               burst_cnt_nxt = 4'd1;
               rr_last_nxt   = 1'b1;
            end else begin
               state_nxt   = IDLE;
               rr_last_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m0_gnt    = gnt0_c & ~reset;
   assign m1_gnt    = gnt1_c & ~reset;
   assign en        = m0_gnt | m1_gnt;
   assign we        = m0_gnt ? m0_we    : (m1_gnt ? m1_we    : 1'b0);
   assign addr      = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
   assign dataW     = m0_gnt ? m0_dataW : (m1_gnt ? m1_dataW : '0);
   assign m0_rvalid = rd_pend[0] & ~reset;
   assign m1_rvalid = rd_pend[1] & ~reset;
   assign m_dataR   = dataR;

   // Arbitration state and one-cycle read-return tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         rr_last   <= 1'b1;
         rd_pend   <= 2'b00;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= burst_cnt_nxt;
         rr_last    <= rr_last_nxt;
         rd_pend[0] <= m0_gnt & ~m0_we;
         rd_pend[1] <= m1_gnt & ~m1_we;
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_gnt0 <= 32'd0;
         stat_gnt1 <= 32'd0;
         stat_wait <= 32'd0;
      end else begin
         stat_gnt0 <= stat_gnt0 + {31'd0, m0_gnt};
         stat_gnt1 <= stat_gnt1 + {31'd0, m1_gnt};
         stat_wait <= stat_wait + {31'd0, (m0_en & ~m0_gnt) | (m1_en & ~m1_gnt)};
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (define ARB_STATS_EN to cover the counters).
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_en, m0_we, m1_en, m1_we;
   logic [AW-1:0] m0_addr, m1_addr, addr;
   logic [DW-1:0] m0_dataW, m1_dataW, dataW, m_dataR;
   logic [DW-1:0] dataR = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, en, we;
`ifdef ARB_STATS_EN
   logic [31:0]   stat_gnt0, stat_gnt1, stat_wait;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   mem_port_arbiter #(.MAX_BURST(4), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dataW),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dataW),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m_dataR(m_dataR), .addr(addr), .dataW(dataW), .en(en), .we(we), .dataR(dataR)
`ifdef ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_wait(stat_wait)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: read data = address + 0x100, one cycle after the request
   always @(posedge clk)
      dataR <= (en && !we) ? ({16'd0, addr} + 32'h100) : 32'd0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e0, input logic w0, input logic [AW-1:0] a0,
                        input logic e1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1);
      m0_en = e0; m0_we = w0; m0_addr = a0; m0_dataW = 32'h0;
      m1_en = e1; m1_we = w1; m1_addr = a1; m1_dataW = d1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc();
      reset = 1'b0;
   endtask

   int pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

   initial begin
      reset = 1'b1;
      drive(1, 0, 16'd3, 1, 0, 16'd4, 0);
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_gnt0", {31'd0, m0_gnt}, 0);
      chk("rst_gnt1", {31'd0, m1_gnt}, 0);
      chk("rst_en", {31'd0, en}, 0);
      chk("rst_rvalid0", {31'd0, m0_rvalid}, 0);

      // Single requester read stream
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, AW'(i), 0, 0, 0, 0);
         @(negedge clk);
         chk("t1_gnt0", {31'd0, m0_gnt}, 1);
         chk("t1_addr", {16'd0, addr}, i);
         chk("t1_rvalid1", {31'd0, m1_rvalid}, 0);
         if (i > 0) begin
            chk("t1_rvalid0", {31'd0, m0_rvalid}, 1);
            chk("t1_dataR", m_dataR, 32'h100 + i - 1);
         end else begin
            chk("t1_rvalid0_first", {31'd0, m0_rvalid}, 0);
         end
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_rvalid0_last", {31'd0, m0_rvalid}, 1);
      chk("t1_dataR_last", m_dataR, 32'h109);
      chk("t1_idle_en", {31'd0, en}, 0);
      cyc();

      // Dual contention from reset: burst of 4 per owner
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive(1, 0, AW'(100 + k), 1, 0, AW'(200 + k), 0);
         @(negedge clk);
         chk("t2_gnt0", {31'd0, m0_gnt}, (pat[k] == 0) ? 1 : 0);
         chk("t2_gnt1", {31'd0, m1_gnt}, (pat[k] == 1) ? 1 : 0);
         chk("t2_en", {31'd0, en}, 1);
         cyc();
      end

      // Owner switch coinciding with read return to the previous owner
      do_reset();
      drive(1, 0, 16'd88, 1, 0, 16'd7, 0);
      @(negedge clk);
      chk("t3_gnt0", {31'd0, m0_gnt}, 1);
      chk("t3_gnt1_wait", {31'd0, m1_gnt}, 0);
      chk("t3_addr88", {16'd0, addr}, 88);
      cyc();
      drive(0, 0, 0, 1, 0, 16'd7, 0);
      @(negedge clk);
      chk("t3_gnt1", {31'd0, m1_gnt}, 1);
      chk("t3_rvalid0", {31'd0, m0_rvalid}, 1);
      chk("t3_dataR", m_dataR, 32'd88 + 32'h100);
      chk("t3_addr7", {16'd0, addr}, 7);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t3_rvalid1", {31'd0, m1_rvalid}, 1);
      chk("t3_rvalid0_off", {31'd0, m0_rvalid}, 0);
      cyc();

      // Write by requester 1
      drive(0, 0, 0, 1, 1, 16'd25432, 32'hDEADBEEF);
      @(negedge clk);
      chk("t4_gnt1", {31'd0, m1_gnt}, 1);
      chk("t4_en", {31'd0, en}, 1);
      chk("t4_we", {31'd0, we}, 1);
      chk("t4_addr", {16'd0, addr}, 25432);
      chk("t4_dataW", dataW, 32'hDEADBEEF);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t4_rvalid0", {31'd0, m0_rvalid}, 0);
      chk("t4_rvalid1", {31'd0, m1_rvalid}, 0);
      chk("t4_idle_we", {31'd0, we}, 0);
      chk("t4_idle_addr", {16'd0, addr}, 0);
      chk("t4_idle_dataW", dataW, 0);
      cyc();

      // Reset one cycle after a read grant discards the pending read
      drive(1, 0, 16'd5, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_gnt0", {31'd0, m0_gnt}, 1);
      cyc();
      reset = 1'b1;
      drive(1, 0, 16'd6, 1, 0, 16'd9, 0);
      @(negedge clk);
      chk("t5_rst_rvalid0", {31'd0, m0_rvalid}, 0);
      chk("t5_rst_gnt0", {31'd0, m0_gnt}, 0);
      chk("t5_rst_en", {31'd0, en}, 0);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("t5_post_rvalid0", {31'd0, m0_rvalid}, 0);
      chk("t5_post_gnt0", {31'd0, m0_gnt}, 1);
      chk("t5_post_gnt1", {31'd0, m1_gnt}, 0);
      cyc();

`ifdef ARB_STATS_EN
      do_reset();
      @(negedge clk);
      chk("t6_clr_gnt0", stat_gnt0, 0);
      chk("t6_clr_wait", stat_wait, 0);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, AW'(k), 1, 0, AW'(k), 0);
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t6_stat_gnt0", stat_gnt0, 4);
      chk("t6_stat_gnt1", stat_gnt1, 4);
      chk("t6_stat_wait", stat_wait, 8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for the single-port 32-bit image memory (16-bit word address, en/we strobes, 1-cycle read latency).
- Lets the edge-detection accelerator (requester 0) and the host image loader/dumper (requester 1) share one memory port.
- Round-robin arbitration with a bounded burst lock, so the accelerator's multi-read pixel-window fetch is not split on every cycle.
- Sits between both requesters and the memory. All requesters stall on gnt=0.

Parameters:
- MAX_BURST, 4, max consecutive grants to one owner while the other requester waits. Legal range 1..15.
- AW, 16, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous reset, active high
- m0_en  in  1  requester 0 access request
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  AW  requester 0 word address
- m0_dataW  in  DW  requester 0 write data
- m0_gnt  out  1  requester 0 access accepted this cycle
- m0_rvalid  out  1  read data for requester 0 valid on m_dataR
- m1_en, m1_we, m1_addr, m1_dataW, m1_gnt, m1_rvalid: as for requester 0
- m_dataR  out  DW  read data returned to both requesters (registered memory output, passed through)
- addr  out  AW  memory address
- dataW  out  DW  memory write data
- en  out  1  memory request
- we  out  1  memory write enable
- dataR  in  DW  memory read data, valid the cycle after a read request

Behaviour:
- Grant path is combinational from registered state plus m*_en; addr/dataW/we are muxed from the granted requester.
- en = m0_gnt | m1_gnt. With no grant: addr=0, dataW=0, we=0.
- Requester rules:
  - Hold en, we, addr and dataW stable until the cycle in which gnt=1.
  - A request with gnt=1 completes in that cycle.
- Registered state:
  - state ∈ {IDLE, OWN0, OWN1}
  - burst_cnt (4 bits)
  - rr_last (last owner)
  - rd_pend[1:0]
- Reset (synchronous): state=IDLE, burst_cnt=0, rr_last=1 (requester 0 wins the first tie), rd_pend=0. While reset=1, all gnt, en, we and rvalid are forced to 0.
- IDLE:
  - Only m0_en → grant 0, next state OWN0, burst_cnt=1.
  - Only m1_en → grant 1, next state OWN1, burst_cnt=1.
  - Both → grant the requester ≠ rr_last; the matching OWNx, burst_cnt=1.
  - Neither → stay in IDLE.
- OWNx (y = other requester):
  - mx_en and (!my_en or burst_cnt < MAX_BURST) → grant x, burst_cnt++ (saturating at MAX_BURST).
  - Else if my_en → grant y, next state OWNy, burst_cnt=1, rr_last=x.
  - Else (neither requesting) → no grant, next state IDLE, rr_last=x.
- At most one grant per cycle. m0_gnt & m1_gnt is never 1.
- Read return:
  - rd_pend[x] <= granted & !we & owner==x.
  - mx_rvalid = rd_pend[x]; m_dataR = dataR.
  - Latency: grant cycle N → rvalid in N+1.
  - Back-to-back reads are fully pipelined: 1 word/cycle.
- Writes complete in the grant cycle; no response.
- Simultaneous events: a switch of owner and a read return for the previous owner in the same cycle are legal. rvalid goes to the previous owner, the grant to the new one.
- Reset mid-burst: the pending read is discarded (rvalid for it never asserts). Arbitration restarts from IDLE with requester 0 favoured.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_gnt0 [31:0], stat_gnt1 [31:0]: grant counts per requester.
  - stat_wait [31:0]: cycles with some mx_en=1 and mx_gnt=0.
- Counters clear on reset and wrap modulo 2^32.
- When undefined: ports absent, no counter logic. Arbitration is identical in both builds.

Test Plan:
- Only m0 issues 10 reads at addrs 0..9 (dataR=addr+0x100 one cycle later) → m0_gnt=1 on all 10 cycles, m0_rvalid=1 on cycles 2..11 with m_dataR=0x100..0x109, m1_rvalid=0 throughout.
- After reset, both assert en in the same cycle and hold continuously, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0,… with no idle cycle between owners.
- m0 reads addr 88 while m1 waits; after 1 grant m0 drops en → next cycle m1_gnt=1, while m0_rvalid=1 on the same cycle.
- m1 writes 0xDEADBEEF to addr 25432 while m0 idle → same cycle en=1, we=1, addr=25432, dataW=0xDEADBEEF; no rvalid asserted.
- Reset asserted in the middle of an m0 read burst (grant at cycle N, reset at N+1) → m0_rvalid=0 at N+1 and N+2. After release with both requesting, the first grant goes to m0.
- ARB_STATS_EN build, 8 cycles of dual contention from reset → stat_gnt0=4, stat_gnt1=4, stat_wait=8.
